l1i_refill_fsm: RTL and testbench
=================================

Name: l1i_refill_fsm

Overview:
Line-refill sequencer for the L1 instruction cache. It sits directly upstream of the L1I bus handshake stage. On an I-fetch miss it drives that stage's 2-bit state input and word address, one word per bus transaction. It collects each returned word and writes it into the data array, then writes the tag when the whole line has arrived. The core sees a busy flag and a completion or error pulse.

Parameters:
WORDS_PER_LINE, 4, 32-bit words per cache line; power of 2, range 2..16
TIMEOUT, 255, maximum cycles to wait for a response in ReadBus; 0 disables the timeout

Ports:
clk  in  1  system clock; all logic updates on the rising edge
rst  in  1  synchronous, active-high reset
Core_req  in  1  miss request; sampled only in Idle
Core_missAddr  in  32  byte address of the missing fetch
Core_flush  in  1  cancel the refill in progress (e.g. on branch redirect)
Refill_busy  out  1  high whenever the state is not Idle
Refill_done  out  1  one-cycle pulse: line complete and tag written
Refill_err  out  1  one-cycle pulse: refill aborted by timeout
FSM_current_state  out  2  to the bus handshake stage: 00 Idle, 10 ReadBus, 11 WriteCache; 01 (WriteBus) is never driven
Bus_hand_aBitsAddress  out  32  word address of the current bus get
Bus_hand_DataRdBusCond  in  1  valid AccessAckData beat present this cycle
Bus_hand_dBitsData  in  32  data of that beat
Cache_wrEn  out  1  data-array word write strobe
Cache_wrOffset  out  log2(WORDS_PER_LINE)  word index within the line
Cache_wrData  out  32  word to write
Cache_lineAddr  out  32  line-aligned base address, used for index and tag
Cache_tagWrEn  out  1  tag/valid write strobe; one cycle

Behaviour:
- Reset: state Idle; all registers cleared.
  - All outputs 0: FSM_current_state=00, Refill_busy, Refill_done, Refill_err, Cache_wrEn, Cache_tagWrEn, and all address and data outputs.
  - A reset taken mid-refill drops the refill. No tag write occurs.
- Idle:
  - On Core_req=1: latch base = Core_missAddr with its low log2(WORDS_PER_LINE*4) bits cleared.
  - Clear word counter cnt, abort flag and timeout counter; go to ReadBus next cycle.
  - Core_req is ignored in every other state.
- ReadBus:
  - Bus_hand_aBitsAddress = base + cnt*4, stable for the whole state.
  - The timeout counter increments each cycle.
  - On Bus_hand_DataRdBusCond=1: register Bus_hand_dBitsData into wbuf and go to WriteCache.
  - Else if TIMEOUT≠0 and the counter reaches TIMEOUT: pulse Refill_err, go to Idle, no tag write.
- WriteCache (exactly 1 cycle):
  - If abort=0: Cache_wrEn=1, Cache_wrOffset=cnt, Cache_wrData=wbuf, Cache_lineAddr=base.
  - If cnt==WORDS_PER_LINE-1 and abort=0: Cache_tagWrEn=1 and Refill_done=1 in the same cycle, then go to Idle.
  - If cnt==WORDS_PER_LINE-1 and abort=1: go to Idle with no write strobe and no done pulse.
  - Otherwise, if abort=0: cnt increments, timeout counter clears, go to ReadBus.
  - Otherwise (abort=1): go to Idle with no write strobe and no done pulse.
- Flush:
  - Core_flush while in ReadBus sets the sticky abort flag. The outstanding get still completes, so the bus is never left with an orphan response.
  - Core_flush while in WriteCache suppresses that cycle's Cache_wrEn and Cache_tagWrEn, and the state goes to Idle.
  - Core_flush in Idle has no effect.
- Latency: with a same-cycle response, each word takes 2 cycles (ReadBus then WriteCache). Refill_done is asserted 2*WORDS_PER_LINE cycles after the Idle cycle that accepts Core_req.
- Cache_wrEn and Cache_tagWrEn are never asserted outside WriteCache.
- Refill_done and Refill_err are never asserted together.

Test Plan:
- Reset then Core_req with addr 0x0000_1234, WORDS=4, and a response every ReadBus cycle with data 0xA0..0xA3:
  - Addresses 0x1230, 0x1234, 0x1238, 0x123C.
  - Cache_wrEn at offsets 0..3 with wbuf 0xA0..0xA3.
  - Cache_tagWrEn and Refill_done 8 cycles after acceptance; Cache_lineAddr=0x1230.
- Responses delayed by 3 cycles each: FSM stays in 10 and the address is held. The line completes 20 cycles after acceptance.
- Core_flush during word 2 of ReadBus: that get completes, then no wrEn, no tagWrEn and no done; state Idle; a following Core_req starts normally.
- TIMEOUT=8, no response: Refill_err pulses after 8 ReadBus cycles; state returns to 00; no tag write.
- rst asserted during WriteCache of word 1: every output is 0 on the next cycle. A Core_req asserted while busy is ignored.

Source files
------------

// File: rtl/l1i_refill_fsm_if.sv
// Signal bundle between the L1I refill sequencer and its core, bus-handshake and data-array neighbours.
// The master modport belongs to the sequencer; the slave modport is the surrounding environment.
interface l1i_refill_fsm_if #(
    parameter int WORDS_PER_LINE = 4
);
    localparam int OW = $clog2(WORDS_PER_LINE);

    logic          Core_req;
    logic [31:0]   Core_missAddr;
    logic          Core_flush;
    logic          Refill_busy;
    logic          Refill_done;
    logic          Refill_err;
    logic [1:0]    FSM_current_state;
    logic [31:0]   Bus_hand_aBitsAddress;
    logic          Bus_hand_DataRdBusCond;
    logic [31:0]   Bus_hand_dBitsData;
    logic          Cache_wrEn;
    logic [OW-1:0] Cache_wrOffset;
    logic [31:0]   Cache_wrData;
    logic [31:0]   Cache_lineAddr;
    logic          Cache_tagWrEn;

    modport master (
        input  Core_req, Core_missAddr, Core_flush,
        input  Bus_hand_DataRdBusCond, Bus_hand_dBitsData,
        output Refill_busy, Refill_done, Refill_err, FSM_current_state,
        output Bus_hand_aBitsAddress,
        output Cache_wrEn, Cache_wrOffset, Cache_wrData, Cache_lineAddr, Cache_tagWrEn
    );

    modport slave (
        output Core_req, Core_missAddr, Core_flush,
        output Bus_hand_DataRdBusCond, Bus_hand_dBitsData,
        input  Refill_busy, Refill_done, Refill_err, FSM_current_state,
        input  Bus_hand_aBitsAddress,
        input  Cache_wrEn, Cache_wrOffset, Cache_wrData, Cache_lineAddr, Cache_tagWrEn
    );
endinterface

// File: rtl/l1i_refill_fsm.sv
// L1I line-refill sequencer: fetches one word per bus get, writes each into the data array,
// and writes the tag once the whole line is in. A flush or timeout drops the line untagged.
module l1i_refill_fsm #(
    parameter int WORDS_PER_LINE = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    l1i_refill_fsm_if.master        rf
);
    localparam int OW = $clog2(WORDS_PER_LINE);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              TMO_EN    = (TIMEOUT != 0);
    localparam logic [TW-1:0]   TMO_LIM   = TW'(TIMEOUT);
    localparam logic [OW-1:0]   LAST_IDX  = OW'(WORDS_PER_LINE - 1);
    localparam logic [31:0]     LINE_MASK = ~(32'(WORDS_PER_LINE * 4) - 32'd1);

    // Encoding doubles as the handshake stage's state input; 01 is reserved for WriteBus.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b10,
        S_WRITE = 2'b11
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [31:0]   base_r;
    logic [OW-1:0] cnt_r;
    logic          abort_r;
    logic [TW-1:0] tmo_r;
    logic [31:0]   wbuf_r;

    logic          last_s;
    logic          kill_s;
    logic [TW-1:0] tmo_inc_s;
    logic          tmo_hit_s;

    assign last_s    = (cnt_r == LAST_IDX);
    // Reset is folded in so a reset landing on the final WriteCache cannot leave a stray tag write.
    assign kill_s    = abort_r | rf.Core_flush | rst;
    assign tmo_inc_s = tmo_r + TW'(1'b1);
    assign tmo_hit_s = TMO_EN && (tmo_inc_s == TMO_LIM);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (rf.Core_req) begin
                    state_s = S_READ;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ: begin
                if (rf.Bus_hand_DataRdBusCond) begin
                    state_s = S_WRITE;
                end else if (tmo_hit_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_READ;
                end
            end
            S_WRITE: begin
                if (kill_s || last_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_READ;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Refill datapath: line base, word counter, sticky abort, timeout counter and word buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_r  <= 32'd0;
            cnt_r   <= '0;
            abort_r <= 1'b0;
            tmo_r   <= '0;
            wbuf_r  <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (rf.Core_req) begin
                        base_r  <= rf.Core_missAddr & LINE_MASK;
                        cnt_r   <= '0;
                        abort_r <= 1'b0;
                        tmo_r   <= '0;
                    end
                end
                S_READ: begin
                    tmo_r <= tmo_inc_s;
                    if (rf.Core_flush) begin
                        abort_r <= 1'b1;
                    end
                    if (rf.Bus_hand_DataRdBusCond) begin
                        wbuf_r <= rf.Bus_hand_dBitsData;
                    end
                end
                S_WRITE: begin
                    tmo_r <= '0;
                    if (!kill_s && !last_s) begin
                        cnt_r <= cnt_r + OW'(1'b1);
                    end
                end
                default: begin
                    abort_r <= 1'b0;
                end
            endcase
        end
    end

    // Output decode: strobes and pulses only in their own state, addresses straight from registers.
    always_comb begin
        rf.FSM_current_state     = state_r;
        rf.Refill_busy           = (state_r != S_IDLE);
        rf.Bus_hand_aBitsAddress = base_r + {{(30 - OW){1'b0}}, cnt_r, 2'b00};
        rf.Cache_wrOffset        = cnt_r;
        rf.Cache_wrData          = wbuf_r;
        rf.Cache_lineAddr        = base_r;
        rf.Refill_done           = 1'b0;
        rf.Refill_err            = 1'b0;
        rf.Cache_wrEn            = 1'b0;
        rf.Cache_tagWrEn         = 1'b0;
        case (state_r)
            S_READ: begin
                if (!rf.Bus_hand_DataRdBusCond && tmo_hit_s && !rst) begin
                    rf.Refill_err = 1'b1;
                end else begin
                    rf.Refill_err = 1'b0;
                end
            end
            S_WRITE: begin
                rf.Cache_wrEn = !kill_s;
                if (!kill_s && last_s) begin
                    rf.Cache_tagWrEn = 1'b1;
                    rf.Refill_done   = 1'b1;
                end else begin
                    rf.Cache_tagWrEn = 1'b0;
                    rf.Refill_done   = 1'b0;
                end
            end
            default: begin
                rf.Refill_err = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_l1i_refill_fsm.sv
// Randomized bench for l1i_refill_fsm: each refill scenario is expanded into a per-cycle table of
// inputs and expected outputs from the word delays, flush points and data, then played against the DUT.
module tb_l1i_refill_fsm;
    localparam int W   = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l1i_refill_fsm_if #(.WORDS_PER_LINE(W)) bus ();

    l1i_refill_fsm #(.WORDS_PER_LINE(W), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (bus)
    );

    typedef struct {
        bit          rst, req, flush, cond;
        logic [31:0] maddr, rdata;
        bit          chk_ctl, chk_all0, chk_addr;
        logic [1:0]  st;
        bit          busy, err, done, tag, wr;
        logic [31:0] baddr, off, wdata, line;
    } cyc_t;

    cyc_t        tbl[$];
    int          dly[W];
    logic [31:0] wd[W];
    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic cyc_t blank();
        cyc_t c;
        c.rst = 1'b0; c.req = 1'b0; c.flush = 1'b0; c.cond = 1'b0;
        c.maddr = 32'd0; c.rdata = 32'd0;
        c.chk_ctl = 1'b1; c.chk_all0 = 1'b0; c.chk_addr = 1'b0;
        c.st = 2'b00; c.busy = 1'b0; c.err = 1'b0; c.done = 1'b0; c.tag = 1'b0; c.wr = 1'b0;
        c.baddr = 32'd0; c.off = 32'd0; c.wdata = 32'd0; c.line = 32'd0;
        return c;
    endfunction

    task automatic push_idle();
        cyc_t c;
        c = blank();
        c.flush = ($urandom_range(0, 1) == 1);
        c.rdata = $urandom;
        tbl.push_back(c);
    endtask

    // One refill: f_rd/f_wc = word whose ReadBus (first cycle) / WriteCache sees Core_flush, rst_w = word
    // whose WriteCache sees rst; -1 disables each.
    task automatic add_refill(input logic [31:0] addr, input int f_rd, input int f_wc, input int rst_w);
        cyc_t        c;
        logic [31:0] base;
        bit          ab;
        bit          ab2;
        base = addr & ~(32'(W * 4) - 32'd1);
        ab   = 1'b0;
        c = blank();
        c.req = 1'b1;
        c.maddr = addr;
        tbl.push_back(c);
        for (int i = 0; i < W; i++) begin
            for (int k = 0; ; k++) begin
                c = blank();
                c.st = 2'b10; c.busy = 1'b1; c.chk_addr = 1'b1;
                c.baddr = base + 32'(4 * i);
                c.req = ($urandom_range(0, 3) == 0);
                c.maddr = $urandom;
                if (i == f_rd && k == 0) begin
                    c.flush = 1'b1;
                    ab = 1'b1;
                end
                if (k == dly[i]) begin
                    c.cond = 1'b1;
                    c.rdata = wd[i];
                    tbl.push_back(c);
                    break;
                end
                c.rdata = $urandom;
                if (k + 1 == TMO) begin
                    c.err = 1'b1;
                    tbl.push_back(c);
                    push_idle();
                    return;
                end
                tbl.push_back(c);
            end
            c = blank();
            c.st = 2'b11; c.busy = 1'b1;
            c.req = ($urandom_range(0, 3) == 0);
            c.maddr = $urandom;
            c.rdata = $urandom;
            c.flush = (i == f_wc);
            ab2 = ab | c.flush;
            if (i == rst_w) begin
                c.rst = 1'b1;
                c.chk_ctl = 1'b0;
                tbl.push_back(c);
                c = blank();
                c.chk_all0 = 1'b1;
                tbl.push_back(c);
                return;
            end
            c.wr = !ab2;
            c.off = 32'(i);
            c.wdata = wd[i];
            c.line = base;
            c.tag = !ab2 && (i == W - 1);
            c.done = c.tag;
            tbl.push_back(c);
            if (ab2 || i == W - 1) begin
                push_idle();
                return;
            end
        end
    endtask

    task automatic set_words(input int d, input logic [31:0] d0);
        for (int i = 0; i < W; i++) begin
            dly[i] = d;
            wd[i]  = d0 + 32'(i);
        end
    endtask

    task automatic play();
        cyc_t c;
        while (tbl.size() > 0) begin
            c = tbl.pop_front();
            @(negedge clk);
            rst                        = c.rst;
            bus.Core_req               = c.req;
            bus.Core_missAddr          = c.maddr;
            bus.Core_flush             = c.flush;
            bus.Bus_hand_DataRdBusCond = c.cond;
            bus.Bus_hand_dBitsData     = c.rdata;
            #1;
            if (c.chk_ctl || c.chk_all0) begin
                check_val("state", 32'(bus.FSM_current_state), 32'(c.st));
                check_val("busy",  32'(bus.Refill_busy),       32'(c.busy));
                check_val("done",  32'(bus.Refill_done),       32'(c.done));
                check_val("err",   32'(bus.Refill_err),        32'(c.err));
                check_val("wren",  32'(bus.Cache_wrEn),        32'(c.wr));
                check_val("tagwr", 32'(bus.Cache_tagWrEn),     32'(c.tag));
            end
            if (c.chk_all0 || c.chk_addr) begin
                check_val("baddr", bus.Bus_hand_aBitsAddress, c.baddr);
            end
            if (c.chk_all0 || c.wr) begin
                check_val("wroff",  32'(bus.Cache_wrOffset), c.off);
                check_val("wrdata", bus.Cache_wrData,        c.wdata);
                check_val("line",   bus.Cache_lineAddr,      c.line);
            end
            cyc++;
        end
    endtask

    initial begin
        cyc_t c;
        int   f_rd;
        int   f_wc;
        int   r_w;
        bus.Core_req = 1'b0; bus.Core_missAddr = 32'd0; bus.Core_flush = 1'b0;
        bus.Bus_hand_DataRdBusCond = 1'b0; bus.Bus_hand_dBitsData = 32'd0;

        c = blank(); c.rst = 1'b1; c.chk_ctl = 1'b0; tbl.push_back(c);
        c = blank(); c.rst = 1'b1; c.chk_all0 = 1'b1; tbl.push_back(c);
        c = blank(); c.chk_all0 = 1'b1; tbl.push_back(c);
        play();

        set_words(0, 32'h0000_00A0);
        add_refill(32'h0000_1234, -1, -1, -1);
        set_words(3, $urandom);
        add_refill(32'h0000_1234, -1, -1, -1);
        set_words(0, $urandom);
        dly[2] = 1;
        add_refill(32'h8000_0F0C, 2, -1, -1);
        set_words(0, $urandom);
        add_refill(32'h0000_2000, -1, -1, -1);
        set_words(0, $urandom);
        dly[0] = 100;
        add_refill(32'hDEAD_BEEF, -1, -1, -1);
        set_words(1, $urandom);
        add_refill(32'h1234_5678, -1, -1, 1);
        set_words(0, $urandom);
        add_refill(32'h0000_4444, -1, 3, -1);
        play();

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < W; i++) begin
                dly[i] = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 3);
                wd[i]  = $urandom;
            end
            f_rd = ($urandom_range(0, 4) == 0) ? $urandom_range(0, W - 1) : -1;
            f_wc = ($urandom_range(0, 5) == 0) ? $urandom_range(0, W - 1) : -1;
            r_w  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, W - 1) : -1;
            add_refill($urandom, f_rd, f_wc, r_w);
            play();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
